rtc_poll_sequencer: RTL and testbench

// - Periodically sweeps the RTC registers through the RTC bus driver and turns each BCD byte into
//   the digit0_*/digit1_* nibbles, AM_PM, and formato_hora that feed Clock_screen_top.
// - Replaces bloque_prueba_frames in the live top level, sitting between the RTC bus driver and the VGA screen block.
// - All screen outputs update together at the end of a sweep, so a frame never shows a torn time.

---
 rtl/rtc_map_pkg.sv | 58 +++++
 rtl/bcd_byte_split.sv | 13 +
 rtl/rtc_poll_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_rtc_poll_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_map_pkg.sv
// rtc_map_pkg: RTC register map, FSM state encoding and shared types for the
// RTC poll sequencer. Optional feature macro: TIMER_READ_EN (adds the timer
// registers 0x41-0x43 to the sweep).
package rtc_map_pkg;

    // RTC register addresses, in sweep order
    localparam logic [7:0] REG_SS   = 8'h21;
    localparam logic [7:0] REG_MM   = 8'h22;
    localparam logic [7:0] REG_HH   = 8'h23;
    localparam logic [7:0] REG_DAY  = 8'h24;
    localparam logic [7:0] REG_MES  = 8'h25;
    localparam logic [7:0] REG_YEAR = 8'h26;
`ifdef TIMER_READ_EN
    localparam logic [7:0] REG_SS_T = 8'h41;
    localparam logic [7:0] REG_MM_T = 8'h42;
    localparam logic [7:0] REG_HH_T = 8'h43;
    localparam int N_REGS = 9;
`else
    localparam int N_REGS = 6;
`endif

    // Hours byte layout
    localparam int FMT_BIT = 7;
    localparam int PM_BIT  = 5;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Tens/units pair driven to the screen
    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d0;
    } digit_pair_t;

    // Sweep index to RTC register address
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = REG_SS;
            4'd1:    a = REG_MM;
            4'd2:    a = REG_HH;
            4'd3:    a = REG_DAY;
            4'd4:    a = REG_MES;
            4'd5:    a = REG_YEAR;
`ifdef TIMER_READ_EN
            4'd6:    a = REG_SS_T;
            4'd7:    a = REG_MM_T;
            4'd8:    a = REG_HH_T;
`endif
            default: a = REG_SS;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/bcd_byte_split.sv
// bcd_byte_split: generic BCD byte to {tens, units} split. Bit 7 is ignored
// and nibbles above 9 pass through unchanged.
module bcd_byte_split
    import rtc_map_pkg::*;
(
    input  logic [7:0]  i_byte,
    output digit_pair_t o_pair
);

    assign o_pair.d0 = i_byte[3:0];
    assign o_pair.d1 = {1'b0, i_byte[6:4]};

endmodule

// File: rtl/rtc_poll_sequencer.sv
// rtc_poll_sequencer: periodically reads the RTC time/date (and optionally
// timer) registers through the bus driver, captures them in shadow registers
// and commits all screen digits in a single cycle at the end of a sweep.
// Optional feature macro: TIMER_READ_EN (timer registers read and *_T driven;
// otherwise *_T are tied to 0).
module rtc_poll_sequencer
    import rtc_map_pkg::*;
#(
    parameter int POLL_CYCLES = 100_000_000,
    parameter int TIMEOUT     = 255,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pause,
    output logic              rtc_req,
    output logic [ADDR_W-1:0] rtc_addr,
    input  logic              rtc_ack,
    input  logic [7:0]        rtc_rdata,
    output logic [3:0]        digit0_SS,   digit1_SS,
    output logic [3:0]        digit0_MM,   digit1_MM,
    output logic [3:0]        digit0_HH,   digit1_HH,
    output logic [3:0]        digit0_DAY,  digit1_DAY,
    output logic [3:0]        digit0_MES,  digit1_MES,
    output logic [3:0]        digit0_YEAR, digit1_YEAR,
    output logic [3:0]        digit0_SS_T, digit1_SS_T,
    output logic [3:0]        digit0_MM_T, digit1_MM_T,
    output logic [3:0]        digit0_HH_T, digit1_HH_T,
    output logic              AM_PM,
    output logic              formato_hora,
    output logic              sweep_done,
    output logic              bus_err
);

    localparam int TICK_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IDX_W  = $clog2(N_REGS);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(POLL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REGS - 1);

    logic [TICK_W-1:0] r_tick;
    logic [WAIT_W-1:0] r_wait;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_state;
    logic              r_req, r_done, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_shadow [N_REGS];
    logic              w_tick;

    digit_pair_t w_ss, w_mm, w_day, w_mes, w_yr, w_hh;
    digit_pair_t r_ss, r_mm, r_day, r_mes, r_yr, r_hh;
    logic        w_fmt, w_ampm, r_fmt, r_ampm;

    // Sweep period counter; wraps every POLL_CYCLES cycles
    always_ff @(posedge clock) begin
        if (reset || (r_tick == TICK_MAX)) r_tick <= '0;
        else                               r_tick <= r_tick + TICK_W'(1);
    end

    assign w_tick = (r_tick == TICK_MAX) && !pause;

    // Sweep FSM: request each register, capture its byte, abort on timeout
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_wait  <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < N_REGS; i++) r_shadow[i] <= 8'h00;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) r_state <= ST_REQ;
                end
                ST_REQ: begin
                    r_req   <= 1'b1;
                    r_addr  <= ADDR_W'(reg_addr(4'(r_idx)));
                    r_wait  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rtc_ack) begin
                        r_shadow[r_idx] <= rtc_rdata;
                        r_req           <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= ST_REQ;
                        end
                    end else if (r_wait == WAIT_MAX) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    r_done  <= 1'b1;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    bcd_byte_split u_split_ss  (.i_byte(r_shadow[0]), .o_pair(w_ss));
    bcd_byte_split u_split_mm  (.i_byte(r_shadow[1]), .o_pair(w_mm));
    bcd_byte_split u_split_day (.i_byte(r_shadow[3]), .o_pair(w_day));
    bcd_byte_split u_split_mes (.i_byte(r_shadow[4]), .o_pair(w_mes));
    bcd_byte_split u_split_yr  (.i_byte(r_shadow[5]), .o_pair(w_yr));

    // Hours decode: bit 7 selects 12 h (PM flag in bit 5) or 24 h layout
    always_comb begin
        w_fmt   = r_shadow[2][FMT_BIT];
        w_hh.d0 = r_shadow[2][3:0];
        if (w_fmt) begin
            w_ampm  = r_shadow[2][PM_BIT];
            w_hh.d1 = {3'b000, r_shadow[2][4]};
        end else begin
            w_ampm  = 1'b0;
            w_hh.d1 = {2'b00, r_shadow[2][5:4]};
        end
    end

    // Screen outputs load together on commit so a frame never shows a torn time
    always_ff @(posedge clock) begin
        if (reset) begin
            {r_ss, r_mm, r_hh, r_day, r_mes, r_yr} <= '0;
            r_fmt  <= 1'b0;
            r_ampm <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            {r_ss, r_mm, r_hh, r_day, r_mes, r_yr} <= {w_ss, w_mm, w_hh, w_day, w_mes, w_yr};
            r_fmt  <= w_fmt;
            r_ampm <= w_ampm;
        end
    end

`ifdef TIMER_READ_EN
    digit_pair_t w_sst, w_mmt, w_hht, r_sst, r_mmt, r_hht;

    bcd_byte_split u_split_sst (.i_byte(r_shadow[6]), .o_pair(w_sst));
    bcd_byte_split u_split_mmt (.i_byte(r_shadow[7]), .o_pair(w_mmt));
    // Timer hours always use the 24 h layout
    assign w_hht.d1 = {2'b00, r_shadow[8][5:4]};
    assign w_hht.d0 = r_shadow[8][3:0];

    // Timer digits commit alongside the time and date digits
    always_ff @(posedge clock) begin
        if (reset)                      {r_sst, r_mmt, r_hht} <= '0;
        else if (r_state == ST_COMMIT)  {r_sst, r_mmt, r_hht} <= {w_sst, w_mmt, w_hht};
    end

    assign {digit1_SS_T, digit0_SS_T} = r_sst;
    assign {digit1_MM_T, digit0_MM_T} = r_mmt;
    assign {digit1_HH_T, digit0_HH_T} = r_hht;
`else
    assign {digit1_SS_T, digit0_SS_T} = 8'h00;
    assign {digit1_MM_T, digit0_MM_T} = 8'h00;
    assign {digit1_HH_T, digit0_HH_T} = 8'h00;
`endif

    assign rtc_req      = r_req;
    assign rtc_addr     = r_addr;
    assign sweep_done   = r_done;
    assign bus_err      = r_err;
    assign AM_PM        = r_ampm;
    assign formato_hora = r_fmt;
    assign {digit1_SS,   digit0_SS}   = r_ss;
    assign {digit1_MM,   digit0_MM}   = r_mm;
    assign {digit1_HH,   digit0_HH}   = r_hh;
    assign {digit1_DAY,  digit0_DAY}  = r_day;
    assign {digit1_MES,  digit0_MES}  = r_mes;
    assign {digit1_YEAR, digit0_YEAR} = r_yr;

endmodule

// File: tb/tb_rtc_poll_sequencer.sv
// tb_rtc_poll_sequencer: directed bench with an RTC bus model that acks after
// three cycles, an address/output scoreboard and immediate-assertion checks.
module tb_rtc_poll_sequencer;

    localparam int POLL    = 64;
    localparam int TMO     = 20;
`ifdef TIMER_READ_EN
    localparam int NREG = 9;
`else
    localparam int NREG = 6;
`endif

    logic clock = 1'b0;
    logic reset, pause, rtc_ack;
    logic [7:0] rtc_rdata;
    logic rtc_req, sweep_done, bus_err, AM_PM, formato_hora;
    logic [7:0] rtc_addr;
    logic [3:0] d0ss, d1ss, d0mm, d1mm, d0hh, d1hh, d0day, d1day, d0mes, d1mes, d0yr, d1yr;
    logic [3:0] d0sst, d1sst, d0mmt, d1mmt, d0hht, d1hht;

    rtc_poll_sequencer #(.POLL_CYCLES(POLL), .TIMEOUT(TMO), .ADDR_W(8)) dut (
        .clock(clock), .reset(reset), .pause(pause),
        .rtc_req(rtc_req), .rtc_addr(rtc_addr), .rtc_ack(rtc_ack), .rtc_rdata(rtc_rdata),
        .digit0_SS(d0ss), .digit1_SS(d1ss), .digit0_MM(d0mm), .digit1_MM(d1mm),
        .digit0_HH(d0hh), .digit1_HH(d1hh), .digit0_DAY(d0day), .digit1_DAY(d1day),
        .digit0_MES(d0mes), .digit1_MES(d1mes), .digit0_YEAR(d0yr), .digit1_YEAR(d1yr),
        .digit0_SS_T(d0sst), .digit1_SS_T(d1sst), .digit0_MM_T(d0mmt), .digit1_MM_T(d1mmt),
        .digit0_HH_T(d0hht), .digit1_HH_T(d1hht),
        .AM_PM(AM_PM), .formato_hora(formato_hora),
        .sweep_done(sweep_done), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    wire [73:0] w_obs = {d1ss, d0ss, d1mm, d0mm, d1hh, d0hh, d1day, d0day, d1mes, d0mes,
                         d1yr, d0yr, d1sst, d0sst, d1mmt, d0mmt, d1hht, d0hht, AM_PM, formato_hora};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int n_req = 0;
    logic [7:0]  mem [256];
    logic [7:0]  noack_addr = 8'hFF;
    logic [7:0]  q_addr [$];
    logic [73:0] q_snap [$];

    function automatic logic [7:0] split(input logic [7:0] b);
        return {1'b0, b[6:4], b[3:0]};
    endfunction

    // Independent expected output image from the RTC model contents
    function automatic logic [73:0] exp_from_mem();
        logic [7:0] hh, hdig, tim;
        logic ampm;
        hh = mem[8'h23];
        if (hh[7]) begin
            hdig = {3'b000, hh[4], hh[3:0]};
            ampm = hh[5];
        end else begin
            hdig = {2'b00, hh[5:4], hh[3:0]};
            ampm = 1'b0;
        end
`ifdef TIMER_READ_EN
        tim = mem[8'h43];
        return {split(mem[8'h21]), split(mem[8'h22]), hdig, split(mem[8'h24]),
                split(mem[8'h25]), split(mem[8'h26]), split(mem[8'h41]), split(mem[8'h42]),
                {2'b00, tim[5:4], tim[3:0]}, ampm, hh[7]};
`else
        tim = 8'h00;
        return {split(mem[8'h21]), split(mem[8'h22]), hdig, split(mem[8'h24]),
                split(mem[8'h25]), split(mem[8'h26]), tim, tim, tim, ampm, hh[7]};
`endif
    endfunction

    task automatic push_addrs(input int n);
        logic [7:0] tbl [9];
        tbl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        for (int i = 0; i < n; i++) q_addr.push_back(tbl[i]);
    endtask

    task automatic expect_sweep();
        push_addrs(NREG);
        q_snap.push_back(exp_from_mem());
    endtask

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int target, input int max_cyc);
        int k = 0;
        while (done_cnt < target && k < max_cyc) begin
            @(negedge clock);
            k++;
        end
        chk("sweep_done_wait", 74'(done_cnt >= target), 74'(1));
    endtask

    // Cycle counter for latency measurement
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // RTC bus model: ack three cycles after rtc_req is seen high
    initial begin
        int mcnt = 0;
        rtc_ack = 1'b0;
        rtc_rdata = 8'h00;
        forever begin
            @(negedge clock);
            rtc_ack = 1'b0;
            if (rtc_req && !reset) begin
                mcnt++;
                if (mcnt == 3 && rtc_addr != noack_addr) begin
                    rtc_ack   = 1'b1;
                    rtc_rdata = mem[rtc_addr];
                    mcnt      = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: request addresses, committed outputs and timeout latency
    initial begin
        logic prev_req = 1'b0;
        logic chk_next = 1'b0;
        int   rise_cyc = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (chk_next) chk("req_low_after_err", 74'(rtc_req), 74'(0));
                chk_next = 1'b0;
                if (rtc_req && !prev_req) begin
                    n_req++;
                    rise_cyc = cyc;
                    chk("req_addr", 74'(rtc_addr),
                        74'((q_addr.size() > 0) ? q_addr.pop_front() : 8'hFF));
                end
                if (sweep_done) begin
                    done_cnt++;
                    chk("commit_outputs", w_obs, (q_snap.size() > 0) ? q_snap.pop_front() : '1);
                end
                if (bus_err) begin
                    err_cnt++;
                    chk("timeout_latency", 74'(cyc - rise_cyc), 74'(TMO));
                    chk("req_low_at_err", 74'(rtc_req), 74'(0));
                    chk_next = 1'b1;
                end
            end
            prev_req = rtc_req;
        end
    end

    initial begin
        logic [73:0] saved;
        int sreq, sdone, k;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h59; mem[8'h22] = 8'h34; mem[8'h23] = 8'h23;
        mem[8'h24] = 8'h31; mem[8'h25] = 8'h12; mem[8'h26] = 8'h16;
        mem[8'h41] = 8'h05; mem[8'h42] = 8'h10; mem[8'h43] = 8'h01;
        reset = 1'b1;
        pause = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", w_obs, 74'(0));
        chk("reset_req", 74'({rtc_req, rtc_addr, sweep_done, bus_err}), 74'(0));
        reset = 1'b0;

        // First sweep: 24 h time
        expect_sweep();
        wait_done(1, 200);
        repeat (4) @(negedge clock);
        chk("one_sweep_done", 74'(done_cnt), 74'(1));
        chk("req_count", 74'(n_req), 74'(NREG));
        chk("ss_digits", 74'({d1ss, d0ss}), 74'(8'h59));
        chk("hh_digits", 74'({d1hh, d0hh}), 74'(8'h23));
        chk("fmt_ampm_24h", 74'({formato_hora, AM_PM}), 74'(2'b00));
`ifdef TIMER_READ_EN
        chk("timer_digits", 74'({d1sst, d0sst, d1mmt, d0mmt, d1hht, d0hht}), 74'(24'h051001));
`else
        chk("timer_tied_0", 74'({d1sst, d0sst, d1mmt, d0mmt, d1hht, d0hht}), 74'(0));
`endif

        // Second sweep: 12 h PM hours byte
        mem[8'h23] = 8'hB1;
        expect_sweep();
        wait_done(2, 200);
        chk("hh_12h_pm", 74'({formato_hora, AM_PM, d1hh, d0hh}), 74'(10'b11_0001_0001));

        // Timeout on the hours read: outputs must hold
        mem[8'h21] = 8'h07;
        noack_addr = 8'h23;
        push_addrs(3);
        saved = w_obs;
        k = 0;
        while (err_cnt < 1 && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("bus_err_seen", 74'(err_cnt), 74'(1));
        @(negedge clock);
        chk("hold_after_err", w_obs, saved);
        noack_addr = 8'hFF;
        expect_sweep();
        wait_done(3, 200);
        chk("ss_after_recover", 74'({d1ss, d0ss}), 74'(8'h07));

        // Pause across three tick periods
        mem[8'h21] = 8'h42;
        pause = 1'b1;
        saved = w_obs;
        sreq = n_req;
        sdone = done_cnt;
        repeat (3 * POLL) @(negedge clock);
        chk("pause_no_req", 74'(n_req), 74'(sreq));
        chk("pause_no_done", 74'(done_cnt), 74'(sdone));
        chk("pause_hold", w_obs, saved);
        pause = 1'b0;
        expect_sweep();
        wait_done(4, 200);

        // Reset while waiting on the fourth entry
        mem[8'h24] = 8'h15;
        push_addrs(4);
        k = 0;
        while (!(rtc_req && rtc_addr == 8'h24) && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("reached_entry4", 74'({rtc_req, rtc_addr}), 74'(9'h124));
        reset = 1'b1;
        @(negedge clock);
        chk("midsweep_reset_req", 74'({rtc_req, sweep_done, bus_err}), 74'(0));
        chk("midsweep_reset_out", w_obs, 74'(0));
        reset = 1'b0;
        chk("addr_queue_drained", 74'(q_addr.size()), 74'(0));
        expect_sweep();
        wait_done(5, 200);
        chk("day_after_reset", 74'({d1day, d0day}), 74'(8'h15));
        chk("snap_queue_drained", 74'(q_snap.size() + q_addr.size()), 74'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
